// File: rtl/fmcw_adc_pkg.sv
// Shared types and helpers for the FMCW ADC capture path: capture state
// encoding, channel-mode codes and the full-scale saturation value.
package fmcw_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    localparam logic [1:0] MODE_CH0 = 2'd0;
    localparam logic [1:0] MODE_SEL = 2'd1;
    localparam logic [1:0] MODE_RR  = 2'd2;

    // Sign-preserving full-scale value for a two's-complement word of
    // 'width' bits (1..32): positive gives 2^(w-1)-1, negative gives -2^(w-1).
    // The caller keeps the low 'width' bits.
    function automatic logic [31:0] sat_value(input int unsigned width, input logic sign_bit);
        logic [31:0] ones;
        ones = '1;
        if (sign_bit) begin
            return ones << (width - 1);
        end
        return ones >> (33 - width);
    endfunction

endpackage

// File: rtl/adc_fifo.sv
// First-word-fall-through FIFO for captured ADC words. Bit 0 of each word is
// the frame-end flag; mark_last_i sets it on the most recently written entry
// so a frame still terminates when its final word could not be stored.
// A pop and a push in the same cycle on a full FIFO are both accepted.
module adc_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             mark_last_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [AW-1:0]    tail_idx;
    logic             push_ok;
    logic             pop_ok;

    assign full_o   = (count_q == FULL_CNT);
    assign empty_o  = (count_q == '0);
    assign pop_ok   = pop_i && !empty_o;
    assign push_ok  = push_i && (!full_o || pop_ok);
    assign tail_idx = wr_ptr_q - AW'(1);
    assign rdata_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates the read side.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end else if (mark_last_i && !empty_o) begin
            mem_q[tail_idx][0] <= 1'b1;
        end
    end

endmodule

// File: rtl/adc_capture.sv
// Multi-channel ADC capture front end: registers the ADC bus, decimates,
// captures one SAMPLES-long frame per arm aligned to a sweep rising edge,
// buffers it in adc_fifo and streams it out with channel and frame-end tags.
// Build option: define ADC_SAT_EN to replace overflowed samples with a
// sign-preserving full-scale value; otherwise raw samples pass unchanged.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for arm_i; mode/select latched and flags cleared on arm
// ARMED   | waiting for a sweep rising edge
// CAPTURE | one word pushed per decimation tick until SAMPLES pushes
// DRAIN   | frame fully pushed; waiting for the FIFO to empty
module adc_capture
    import fmcw_adc_pkg::*;
#(
    parameter int IW       = 12,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8,
    parameter int SAMPLES  = 1024,
    parameter int DECW     = 4,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [CHANNELS*IW-1:0] data_i,
    input  logic [CHANNELS-1:0]    of_i,
    input  logic [1:0]             mode_i,
    input  logic [CW-1:0]          sel_i,
    input  logic [DECW-1:0]        dec_i,
    input  logic                   arm_i,
    input  logic                   sweep_i,
    output logic [IW-1:0]          data_o,
    output logic [CW-1:0]          chan_o,
    output logic                   last_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   busy_o,
    output logic                   drop_o,
    output logic                   ovf_o
);

    localparam int FW  = IW + CW + 1;
    localparam int WCW = $clog2(SAMPLES) + 1;
    localparam logic [WCW-1:0] LAST_CNT = WCW'(SAMPLES - 1);
    localparam logic [CW-1:0]  LAST_CH  = CW'(CHANNELS - 1);

    logic [CHANNELS*IW-1:0] data_q;
    logic [CHANNELS-1:0]    of_q;
    logic                   sweep_q;
    logic                   sweep_rise;

    state_e         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [CW-1:0]  sel_q, sel_d;
    logic [CW-1:0]  rr_chan_q, rr_chan_d;
    logic [DECW-1:0] dec_cnt_q, dec_cnt_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic           drop_q, drop_d;
    logic           ovf_q, ovf_d;

    logic           tick;
    logic           push;
    logic           last_w;
    logic [CW-1:0]  cap_chan;
    logic [IW-1:0]  raw_sample;
    logic [IW-1:0]  cap_sample;
    logic           cap_of;

    logic [FW-1:0]  fifo_wdata;
    logic [FW-1:0]  fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic           push_blocked;
    logic           mark_last;

    // Input stage: ADC bus, overflow flags and sweep marker registered once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            of_q    <= '0;
            sweep_q <= 1'b0;
        end else begin
            data_q  <= data_i;
            of_q    <= of_i;
            sweep_q <= sweep_i;
        end
    end

    assign sweep_rise = sweep_i & ~sweep_q;
    assign tick       = (dec_cnt_q == '0);
    assign push       = (state_q == ST_CAPTURE) && tick;
    assign last_w     = (word_cnt_q == LAST_CNT);

    // Channel being captured under the mode latched at arm time.
    always_comb begin
        cap_chan = '0;
        case (mode_q)
            MODE_SEL: cap_chan = sel_q;
            MODE_RR:  cap_chan = rr_chan_q;
            MODE_CH0: cap_chan = '0;
            default:  cap_chan = '0;
        endcase
    end

    // Pick the captured channel's sample and overflow flag out of the bus.
    always_comb begin
        raw_sample = data_q[IW-1:0];
        cap_of     = of_q[0];
        for (int k = 0; k < CHANNELS; k++) begin
            if (cap_chan == CW'(k)) begin
                raw_sample = data_q[k*IW +: IW];
                cap_of     = of_q[k];
            end
        end
    end

`ifdef ADC_SAT_EN
    assign cap_sample = cap_of ? IW'(sat_value(IW, raw_sample[IW-1])) : raw_sample;
`else
    assign cap_sample = raw_sample;
`endif

    assign fifo_wdata   = {cap_sample, cap_chan, last_w};
    assign fifo_pop     = ~fifo_empty & ready_i;
    assign push_blocked = push && fifo_full && !fifo_pop;
    assign mark_last    = push_blocked && last_w;

    // Capture FSM next-state, frame counters and sticky flags.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        sel_d      = sel_q;
        rr_chan_d  = rr_chan_q;
        dec_cnt_d  = dec_cnt_q;
        word_cnt_d = word_cnt_q;
        drop_d     = drop_q;
        ovf_d      = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (arm_i) begin
                    mode_d  = mode_i;
                    sel_d   = (32'(sel_i) < CHANNELS) ? sel_i : '0;
                    drop_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (sweep_rise) begin
                    dec_cnt_d  = '0;
                    rr_chan_d  = '0;
                    word_cnt_d = '0;
                    state_d    = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (tick) begin
                    dec_cnt_d  = (dec_i > DECW'(1)) ? dec_i - DECW'(1) : '0;
                    word_cnt_d = word_cnt_q + 1'b1;
                    rr_chan_d  = (rr_chan_q == LAST_CH) ? '0 : rr_chan_q + 1'b1;
                    if (push_blocked) begin
                        drop_d = 1'b1;
                    end
                    if (cap_of) begin
                        ovf_d = 1'b1;
                    end
                    if (last_w) begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    dec_cnt_d = dec_cnt_q - DECW'(1);
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture FSM and frame-control registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_CH0;
            sel_q      <= '0;
            rr_chan_q  <= '0;
            dec_cnt_q  <= '0;
            word_cnt_q <= '0;
            drop_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            sel_q      <= sel_d;
            rr_chan_q  <= rr_chan_d;
            dec_cnt_q  <= dec_cnt_d;
            word_cnt_q <= word_cnt_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
        end
    end

    adc_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .wdata_i     (fifo_wdata),
        .pop_i       (fifo_pop),
        .mark_last_i (mark_last),
        .rdata_o     (fifo_rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Output fields read as zero whenever nothing is buffered.
    assign {data_o, chan_o, last_o} = fifo_empty ? '0 : fifo_rdata;
    assign valid_o = ~fifo_empty;
    assign busy_o  = (state_q != ST_IDLE);
    assign drop_o  = drop_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_adc_capture.sv
module tb_adc_capture;

    localparam int IW      = 12;
    localparam int CH      = 2;
    localparam int DEPTH   = 8;
    localparam int SAMPLES = 16;
    localparam int DECW    = 4;

`ifdef ADC_SAT_EN
    localparam logic [11:0] SAT_POS = 12'h7FF;
    localparam logic [11:0] SAT_NEG = 12'h800;
`else
    localparam logic [11:0] SAT_POS = 12'h7F0;
    localparam logic [11:0] SAT_NEG = 12'h9AB;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [23:0] data_i = '0;
    logic [1:0]  of_i = '0;
    logic [1:0]  mode_i = '0;
    logic        sel_i = 1'b0;
    logic [3:0]  dec_i = 4'd1;
    logic        arm_i = 1'b0;
    logic        sweep_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [11:0] data_o;
    logic        chan_o, last_o, valid_o, busy_o, drop_o, ovf_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [11:0] q_data[$];
    logic        q_chan[$];
    logic        q_last[$];
    int          q_cyc[$];

    typedef struct {
        logic [1:0]  mode;
        logic        sel;
        logic [3:0]  dec;
        logic [11:0] d0;
        logic [11:0] d1;
        logic [1:0]  of;
        bit          cnt;
        bit          rr;
        logic        chan;
        logic [11:0] e0;
        logic [11:0] e1;
        logic        ovf;
        int          gap;
        bit          ext;
    } vec_t;

    vec_t vecs[11];

    adc_capture #(
        .IW(IW), .CHANNELS(CH), .DEPTH(DEPTH), .SAMPLES(SAMPLES), .DECW(DECW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .of_i(of_i),
        .mode_i(mode_i), .sel_i(sel_i), .dec_i(dec_i), .arm_i(arm_i),
        .sweep_i(sweep_i), .data_o(data_o), .chan_o(chan_o), .last_o(last_o),
        .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o),
        .drop_o(drop_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every transfer, sampled mid-cycle after the inputs settle.
    always @(negedge clk) begin
        #1;
        if (valid_o && ready_i) begin
            q_data.push_back(data_o);
            q_chan.push_back(chan_o);
            q_last.push_back(last_o);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [1:0] mode, input logic sel, input logic [3:0] dec,
                                input logic [11:0] d0, input logic [11:0] d1, input logic [1:0] of,
                                input bit cnt, input bit rr, input logic chan,
                                input logic [11:0] e0, input logic [11:0] e1,
                                input logic ovf, input int gap, input bit ext);
        vec_t v;
        v.mode = mode; v.sel = sel; v.dec = dec; v.d0 = d0; v.d1 = d1; v.of = of;
        v.cnt = cnt; v.rr = rr; v.chan = chan; v.e0 = e0; v.e1 = e1;
        v.ovf = ovf; v.gap = gap; v.ext = ext;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic start_frame(input vec_t v);
        @(negedge clk);
        mode_i = v.mode; sel_i = v.sel; dec_i = v.dec;
        data_i = {v.d1, v.d0}; of_i = v.of; arm_i = 1'b1;
        q_data.delete(); q_chan.delete(); q_last.delete(); q_cyc.delete();
        @(negedge clk);
        arm_i  = 1'b0;
        mode_i = (v.mode == 2'd2) ? 2'd0 : 2'd2;
        sel_i  = ~v.sel;
        @(negedge clk);
        sweep_i = 1'b1;
        if (v.cnt) data_i[11:0] = 12'h010;
    endtask

    task automatic wait_idle(input bit cnt, input bit ext);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (cnt) data_i[11:0] = data_i[11:0] + 12'd1;
            if (i == 3) sweep_i = 1'b0;
            if (ext) begin
                if (i == 5) begin arm_i = 1'b1; mode_i = 2'd1; end
                if (i == 6) arm_i = 1'b0;
                if (i == 8) sweep_i = 1'b1;
                if (i == 10) sweep_i = 1'b0;
            end
            if (i > 0 && !busy_o) done = 1'b1;
        end
        chk("frame_done", {31'd0, done}, 32'd1);
        if (!done) begin
            rst_i = 1'b1;
            @(negedge clk);
            rst_i = 1'b0;
        end
    endtask

    task automatic check_frame(input int r, input vec_t v);
        logic        ec;
        logic [11:0] ed;
        chk($sformatf("r%0d_count", r), q_data.size(), SAMPLES);
        for (int k = 0; k < q_data.size() && k < SAMPLES; k++) begin
            ec = v.rr ? k[0] : v.chan;
            ed = v.cnt ? 12'h010 + 12'(k) : (ec ? v.e1 : v.e0);
            chk($sformatf("r%0d_word%0d", r, k), {18'd0, q_data[k], q_chan[k], q_last[k]},
                {18'd0, ed, ec, (k == SAMPLES - 1)});
            if (k > 0) chk($sformatf("r%0d_gap%0d", r, k), q_cyc[k] - q_cyc[k-1], v.gap);
        end
        chk($sformatf("r%0d_ovf", r), {31'd0, ovf_o}, {31'd0, v.ovf});
        chk($sformatf("r%0d_drop", r), {31'd0, drop_o}, 32'd0);
        chk($sformatf("r%0d_busy", r), {31'd0, busy_o}, 32'd0);
    endtask

    task automatic run_row(input int r);
        start_frame(vecs[r]);
        wait_idle(vecs[r].cnt, vecs[r].ext);
        check_frame(r, vecs[r]);
    endtask

    initial begin
        vec_t v;
        bit   done;
        //            mode  sel dec   d0      d1      of    cnt rr ch  e0       e1       ovf gap ext
        vecs[0]  = mk(2'd0, 0, 4'd1, 12'h123, 12'h456, 2'b00, 0, 0, 0, 12'h123, 12'h456, 0, 1, 0);
        vecs[1]  = mk(2'd1, 1, 4'd1, 12'h123, 12'h456, 2'b00, 0, 0, 1, 12'h123, 12'h456, 0, 1, 0);
        vecs[2]  = mk(2'd3, 1, 4'd2, 12'h0F0, 12'h00F, 2'b00, 0, 0, 0, 12'h0F0, 12'h00F, 0, 2, 0);
        vecs[3]  = mk(2'd2, 0, 4'd3, 12'h0AA, 12'h155, 2'b00, 0, 1, 0, 12'h0AA, 12'h155, 0, 3, 0);
        vecs[4]  = mk(2'd0, 0, 4'd0, 12'h800, 12'h456, 2'b01, 0, 0, 0, 12'h800, 12'h456, 1, 1, 0);
        vecs[5]  = mk(2'd0, 0, 4'd1, 12'h7F0, 12'h456, 2'b01, 0, 0, 0, SAT_POS, 12'h456, 1, 1, 0);
        vecs[6]  = mk(2'd0, 0, 4'd1, 12'h9AB, 12'h456, 2'b01, 0, 0, 0, SAT_NEG, 12'h456, 1, 1, 0);
        vecs[7]  = mk(2'd1, 1, 4'd1, 12'h7F0, 12'h7F0, 2'b01, 0, 0, 1, 12'h7F0, 12'h7F0, 0, 1, 0);
        vecs[8]  = mk(2'd0, 0, 4'd1, 12'h000, 12'h456, 2'b00, 1, 0, 0, 12'h000, 12'h000, 0, 1, 0);
        vecs[9]  = mk(2'd2, 0, 4'd1, 12'h321, 12'h7F0, 2'b10, 0, 1, 0, 12'h321, SAT_POS, 1, 1, 0);
        vecs[10] = mk(2'd0, 0, 4'd1, 12'h7F0, 12'h456, 2'b01, 0, 0, 0, SAT_POS, 12'h456, 1, 1, 1);

        repeat (2) @(negedge clk);
        chk("reset_outputs", {14'd0, valid_o, busy_o, last_o, drop_o, ovf_o, chan_o, data_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk);

        // Backpressure across a whole frame: first DEPTH words kept, last forced on the tail.
        ready_i = 1'b0;
        start_frame(vecs[8]);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            data_i[11:0] = data_i[11:0] + 12'd1;
            if (i == 3) sweep_i = 1'b0;
            if (i == 20) begin
                chk("bp_valid", {31'd0, valid_o}, 32'd1);
                chk("bp_head", {20'd0, data_o}, 32'h010);
                chk("bp_head_last", {31'd0, last_o}, 32'd0);
                chk("bp_drop", {31'd0, drop_o}, 32'd1);
                chk("bp_busy", {31'd0, busy_o}, 32'd1);
            end
        end
        chk("bp_hold", {20'd0, data_o}, 32'h010);
        ready_i = 1'b1;
        wait_idle(1'b0, 1'b0);
        chk("bp_count", q_data.size(), DEPTH);
        for (int k = 0; k < q_data.size() && k < DEPTH; k++) begin
            chk($sformatf("bp_word%0d", k), {18'd0, q_data[k], q_chan[k], q_last[k]},
                {18'd0, 12'h010 + 12'(k), 1'b0, (k == DEPTH - 1)});
        end
        chk("bp_drop_sticky", {31'd0, drop_o}, 32'd1);

        // Reset in the middle of a frame, then a clean frame afterwards.
        start_frame(vecs[5]);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (i == 3) sweep_i = 1'b0;
            if (q_data.size() >= 3) done = 1'b1;
        end
        chk("rst_reach_word3", {31'd0, done}, 32'd1);
        chk("rst_pre_ovf", {31'd0, ovf_o}, 32'd1);
        sweep_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("rst_outputs", {14'd0, valid_o, busy_o, last_o, drop_o, ovf_o, chan_o, data_o}, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_post_quiet", {29'd0, valid_o, busy_o, last_o}, 32'd0);

        for (int r = 0; r < 11; r++) begin
            run_row(r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
